// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write, read and clear-handshake bus of the multi-port register file
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_PORTS   = 2
);
  logic                           wen0;
  logic [ADDR_WIDTH-1:0]          waddr0;
  logic [DATA_WIDTH-1:0]          wdata0;
  logic                           wen1;
  logic [ADDR_WIDTH-1:0]          waddr1;
  logic [DATA_WIDTH-1:0]          wdata1;
  logic [RD_PORTS*ADDR_WIDTH-1:0] raddr;
  logic [RD_PORTS*DATA_WIDTH-1:0] rdata;
  logic                           clr_req;
  logic                           clr_busy;
  logic                           clr_done;
  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, clr_req,
    input  rdata, clr_busy, clr_done
  );
  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, clr_req,
    output rdata, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: two-write, multi-read register file with zero register, optional bypass and sweep clear
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_PORTS   = 2,
  parameter int BYPASS     = 1
) (
  input logic         clk,
  input logic         rst,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] ra;
  logic [RD_PORTS*DATA_WIDTH-1:0] rdata;
  assign we0 = bus.wen0 && bus.waddr0 != '0 && state_q != SWEEP;
  assign we1 = bus.wen1 && bus.waddr1 != '0 && state_q != SWEEP;
  assign bus.clr_busy = state_q == SWEEP;
  assign bus.clr_done = state_q == DONE;
  assign bus.rdata = rdata;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (we0) mem_d[bus.waddr0] = bus.wdata0;
    // port 1 is written last so it wins an address collision
    if (we1) mem_d[bus.waddr1] = bus.wdata1;
    case (state_q)
      IDLE: begin
        state_d = bus.clr_req ? SWEEP : IDLE;
        cnt_d = (ADDR_WIDTH + 1)'(1);
      end
      SWEEP: begin
        mem_d[cnt_q[ADDR_WIDTH-1:0]] = '0;
        cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
        state_d = cnt_q == LAST ? DONE : SWEEP;
      end
      default: state_d = IDLE;
    endcase
    mem_d[0] = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= (ADDR_WIDTH + 1)'(1);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
  always_comb begin
    rdata = '0;
    ra = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      ra = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      rdata[k*DATA_WIDTH +: DATA_WIDTH] =
        (rst || ra == '0)                           ? '0 :
        (BYPASS != 0 && we1 && bus.waddr1 == ra)    ? bus.wdata1 :
        (BYPASS != 0 && we0 && bus.waddr0 == ra)    ? bus.wdata0 :
                                                      mem_q[ra];
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: vector table plus sweep/reset sequences against bypass and non-bypass instances
module tb_reg_file_mp;
  localparam int DW = 32, AW = 5, RP = 2;
  logic clk = 0, rst;
  always #5 clk = ~clk;
  reg_file_mp_if #(DW, AW, RP) bus ();
  reg_file_mp_if #(DW, AW, RP) bus_nb ();
  assign bus_nb.wen0 = bus.wen0;
  assign bus_nb.waddr0 = bus.waddr0;
  assign bus_nb.wdata0 = bus.wdata0;
  assign bus_nb.wen1 = bus.wen1;
  assign bus_nb.waddr1 = bus.waddr1;
  assign bus_nb.wdata1 = bus.wdata1;
  assign bus_nb.raddr = bus.raddr;
  assign bus_nb.clr_req = bus.clr_req;
  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_PORTS(RP), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_PORTS(RP), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb.slave));
  typedef struct {
    logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [AW-1:0] r0, r1;
    logic [DW-1:0] e0, e1, n0, n1;
  } vec_t;
  typedef struct { logic [DW-1:0] e0, e1, n0, n1; } exp_t;
  vec_t tbl [13];
  exp_t sb [$];
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] rd(input logic [RP*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction
  task automatic setr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask
  task automatic idle_in();
    bus.wen0 = 0; bus.waddr0 = 0; bus.wdata0 = 0;
    bus.wen1 = 0; bus.waddr1 = 0; bus.wdata1 = 0;
    bus.clr_req = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_in();
    bus.wen0 = 1; bus.waddr0 = a; bus.wdata0 = d;
    step();
    idle_in();
  endtask
  task automatic sweep(input bit inj, output int nb, output int nd, output int di);
    nb = 0; nd = 0; di = -1;
    for (int i = 0; i < 40; i++) begin
      idle_in();
      setr(0, 0);
      if (inj && i == 5) begin
        bus.wen0 = 1; bus.waddr0 = 9; bus.wdata0 = 99; bus.clr_req = 1; setr(9, 9);
      end
      if (inj && i == 10) setr(5, 20);
      if (inj && i == 31) begin
        bus.wen0 = 1; bus.waddr0 = 4; bus.wdata0 = 32'h44; setr(4, 4);
      end
      @(negedge clk);
      nb += int'(bus.clr_busy);
      if (bus.clr_done) begin nd++; di = i; end
      if (inj && i == 5) chk("sweep_write_no_bypass", rd(bus.rdata, 0), 9);
      if (inj && i == 10) begin
        chk("swept_entry", rd(bus.rdata, 0), 0);
        chk("unswept_entry", rd(bus_nb.rdata, 1), 20);
      end
      if (inj && i == 31) begin
        chk("done_write_byp", rd(bus.rdata, 0), 32'h44);
        chk("done_write_nb", rd(bus_nb.rdata, 1), 0);
      end
      step();
    end
  endtask
  initial begin
    int nb, nd, di;
    exp_t e;
    tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            5, 0,  32'hDEADBEEF, 0, 0, 0};
    tbl[1]  = '{0, 0, 0,            0, 0, 0,            5, 0,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    tbl[2]  = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 0,  0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,            0, 0, 0,            0, 5,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 7, 32'h1111,     1, 7, 32'h2222,     7, 7,  32'h2222, 32'h2222, 0, 0};
    tbl[5]  = '{0, 0, 0,            0, 0, 0,            7, 5,  32'h2222, 32'hDEADBEEF, 32'h2222, 32'hDEADBEEF};
    tbl[6]  = '{1, 3, 32'h1,        0, 0, 0,            3, 7,  32'h1, 32'h2222, 0, 32'h2222};
    tbl[7]  = '{1, 3, 32'hA5A5A5A5, 0, 0, 0,            3, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h1};
    tbl[8]  = '{0, 0, 0,            0, 0, 0,            3, 0,  32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0};
    tbl[9]  = '{1, 10, 32'h10,      1, 11, 32'h11,      10, 11, 32'h10, 32'h11, 0, 0};
    tbl[10] = '{1, 12, 32'hC,       1, 0, 32'hBAD,      12, 0, 32'hC, 0, 0, 0};
    tbl[11] = '{0, 0, 0,            1, 12, 32'hD,       12, 10, 32'hD, 32'h10, 32'hC, 32'h10};
    tbl[12] = '{0, 0, 0,            0, 0, 0,            12, 11, 32'hD, 32'h11, 32'hD, 32'h11};
    idle_in();
    bus.wen0 = 1; bus.waddr0 = 5; bus.wdata0 = 32'hDEADBEEF;
    setr(5, 5);
    rst = 1;
    #7;
    chk("reset_rdata_gated", rd(bus.rdata, 0), 0);
    chk("reset_busy", bus.clr_busy, 0);
    chk("reset_done", bus.clr_done, 0);
    idle_in();
    #5;
    rst = 0;
    step();
    foreach (tbl[i]) begin
      bus.wen0 = tbl[i].w0; bus.waddr0 = tbl[i].a0; bus.wdata0 = tbl[i].d0;
      bus.wen1 = tbl[i].w1; bus.waddr1 = tbl[i].a1; bus.wdata1 = tbl[i].d1;
      setr(tbl[i].r0, tbl[i].r1);
      sb.push_back('{tbl[i].e0, tbl[i].e1, tbl[i].n0, tbl[i].n1});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_byp_rd0", i), rd(bus.rdata, 0), e.e0);
      chk($sformatf("vec%0d_byp_rd1", i), rd(bus.rdata, 1), e.e1);
      chk($sformatf("vec%0d_nb_rd0", i), rd(bus_nb.rdata, 0), e.n0);
      chk($sformatf("vec%0d_nb_rd1", i), rd(bus_nb.rdata, 1), e.n1);
      step();
    end
    idle_in();
    for (int a = 1; a < 32; a++) wr(AW'(a), DW'(a));
    bus.clr_req = 1;
    step();
    sweep(1, nb, nd, di);
    chk("sweep_busy_cycles", nb, 31);
    chk("sweep_done_pulses", nd, 1);
    chk("sweep_done_cycle", di, 31);
    for (int a = 1; a < 32; a++) begin
      setr(AW'(a), AW'(a));
      #1;
      chk($sformatf("clear_byp_a%0d", a), rd(bus.rdata, 0), a == 4 ? 32'h44 : 0);
      chk($sformatf("clear_nb_a%0d", a), rd(bus_nb.rdata, 1), a == 4 ? 32'h44 : 0);
    end
    wr(20, 32'h20);
    wr(30, 32'h30);
    bus.clr_req = 1;
    step();
    bus.clr_req = 0;
    repeat (10) step();
    setr(20, 4);
    chk("mid_sweep_busy", bus.clr_busy, 1);
    rst = 1;
    #1;
    chk("rst_mid_busy", bus.clr_busy, 0);
    chk("rst_mid_done", bus.clr_done, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_a20", rd(bus.rdata, 0), 0);
    chk("rst_mid_a4", rd(bus_nb.rdata, 1), 0);
    setr(30, 30);
    #1;
    chk("rst_mid_a30", rd(bus.rdata, 0), 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nd += int'(bus.clr_done);
      step();
    end
    chk("rst_mid_no_done", nd, 0);
    bus.clr_req = 1;
    step();
    sweep(0, nb, nd, di);
    chk("resweep_busy_cycles", nb, 31);
    chk("resweep_done_pulses", nd, 1);
    chk("resweep_done_cycle", di, 31);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port general-purpose register file for the next CPU core generation.
- Two write ports with fixed priority.
- RD_PORTS asynchronous read ports, with optional write-to-read bypass.
- Register 0 is hardwired to zero.
- A sequential clear engine zeroes the whole file on request, one entry per cycle, and signals completion with a handshake.
- Sits between decode (read) and writeback (write) in the core datapath.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
RD_PORTS, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees the stored value only

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wen0  input  1  write enable, port 0
waddr0  input  ADDR_WIDTH  write address, port 0
wdata0  input  DATA_WIDTH  write data, port 0
wen1  input  1  write enable, port 1 (priority port)
waddr1  input  ADDR_WIDTH  write address, port 1
wdata1  input  DATA_WIDTH  write data, port 1
raddr  input  RD_PORTS*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  RD_PORTS*DATA_WIDTH  packed read data; port k = bits [k*DATA_WIDTH +: DATA_WIDTH]
clr_req  input  1  request a full clear sweep
clr_busy  output  1  sweep in progress
clr_done  output  1  one-cycle pulse when the sweep completes

Behaviour:
Reset:
- rst asserted asynchronously zeroes every entry.
- FSM forced to IDLE, sweep counter to 1, clr_busy=0, clr_done=0.
- rdata reads 0 while rst is high.

Writes:
- Writes commit on the rising edge.
- Port n writes when wenN=1, wadrN!=0 and clr_busy=0.
- Same cycle, same address on both ports: port 1 wins and port 0's write is dropped.
- Writes to address 0 are ignored.

Reads:
- Combinational, zero-cycle latency.
- raddr_k==0 always returns 0.
- BYPASS=1 and raddr_k matches an enabled, accepted write this cycle: return that write's data, with port 1 taking priority over port 0.
- Otherwise return the stored entry.
- BYPASS=0: stored entry only. The new value is visible the cycle after the write.

Clear FSM (states IDLE, SWEEP, DONE):
- IDLE: clr_req=1 → SWEEP next cycle, counter=1.
- SWEEP: clr_busy=1. Each cycle the entry at counter is zeroed and the counter increments. On the edge where counter = 2**ADDR_WIDTH-1 is zeroed → DONE.
- DONE: clr_done=1 for exactly one cycle, clr_busy=0 → IDLE.
- Sweep duration is 2**ADDR_WIDTH-1 cycles in SWEEP (31 at default), followed by 1 cycle in DONE.
- clr_req is ignored in SWEEP and DONE; a new request is accepted only in IDLE, including in the cycle right after DONE.
- Writes during SWEEP or DONE... during SWEEP are dropped silently; the upstream stalls on clr_busy. Writes in DONE are accepted.
- Reads during SWEEP return current contents: already-swept entries read 0, unswept entries read their old values. Bypass is inactive because no writes are accepted.
- rst mid-sweep: immediate return to IDLE with all entries zero; no clr_done pulse.

Widths:
- The counter is ADDR_WIDTH+1 bits wide, so the terminal compare cannot wrap.
- Write data is not truncated or extended; all buses are exactly DATA_WIDTH.

Test Plan:
1. Reset then write: rst pulse; wen0=1, waddr0=5, wdata0=32'hDEADBEEF; next cycle raddr port0=5 → rdata port0=32'hDEADBEEF; raddr=0 → 0.
2. Register 0 protection: wen1=1, waddr1=0, wdata1=32'hFFFFFFFF → reading address 0 returns 0 on every port.
3. Write collision: wen0 and wen1 both to address 7 with wdata0=32'h1111, wdata1=32'h2222 → address 7 reads 32'h2222 afterwards. With BYPASS=1, rdata=32'h2222 in the same cycle.
4. Bypass versus no bypass: write address 3 = 32'hA5A5A5A5 while reading address 3 in the same cycle, where it previously held 32'h1 → BYPASS=1 returns A5A5A5A5, BYPASS=0 returns 32'h1.
5. Clear sweep: fill addresses 1..31 with their index; pulse clr_req → clr_busy high for 31 cycles, clr_done pulses once, then all addresses read 0. A write issued mid-sweep to address 9 is dropped, so address 9 still reads 0. A clr_req mid-sweep does not extend the sweep.
6. Reset mid-sweep: assert rst 10 cycles into a sweep → clr_busy=0 immediately, all entries 0, no clr_done pulse. A new clr_req afterwards runs a full 31-cycle sweep.
